// File: rtl/niosbase_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : niosbase_timer_pkg
// Brief    : Register map, bit positions and address split for the timer.
// Revision : 1.0 - initial release
// ============================================================================
package niosbase_timer_pkg;

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD_L = 3'd2,
        REG_PERIOD_H = 3'd3,
        REG_SNAP_L   = 3'd4,
        REG_SNAP_H   = 3'd5,
        REG_PRESCALE = 3'd6,
        REG_PENDING  = 3'd7
    } reg_idx_e;

    localparam int c_sts_to_bit     = 0;
    localparam int c_sts_run_bit    = 1;
    localparam int c_ctrl_ito_bit   = 0;
    localparam int c_ctrl_cont_bit  = 1;
    localparam int c_ctrl_start_bit = 2;
    localparam int c_ctrl_stop_bit  = 3;

    // Sized for the largest supported channel count (16).
    localparam int c_chan_idx_w = 4;
    localparam int c_addr_max_w = c_chan_idx_w + 3;

    typedef struct packed {
        logic [c_chan_idx_w-1:0] chan;
        logic [2:0]              idx;
    } addr_split_t;

    function automatic addr_split_t split_addr(input logic [c_addr_max_w-1:0] addr);
        addr_split_t s;
        s.chan = addr[c_addr_max_w-1:3];
        s.idx  = addr[2:0];
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/niosbase_timer_chan.sv
`default_nettype none
// ============================================================================
// Module   : niosbase_timer_chan
// Brief    : One timer channel: counter, prescaler, period, snapshot, ctl/sts.
// Revision : 1.0 - initial release
// ============================================================================
module niosbase_timer_chan
    import niosbase_timer_pkg::*;
#(
    parameter int          COUNTER_W    = 32,
    parameter int          PRESC_W      = 16,
    parameter logic [63:0] RESET_PERIOD = 64'd499999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr,
    input  logic [2:0]  i_reg,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    // State is held 64/32 bits wide with unused upper bits tied to zero.
    localparam logic [63:0] c_cnt_mask     = (64'd1 << COUNTER_W) - 64'd1;
    localparam logic [31:0] c_presc_mask   = 32'((64'd1 << PRESC_W) - 64'd1);
    localparam logic [63:0] c_reset_period = RESET_PERIOD & c_cnt_mask;

    logic [63:0] r_count_q, w_count_d;
    logic [63:0] r_period_q, w_period_d;
    logic [63:0] r_snap_q, w_snap_d;
    logic [31:0] r_presc_q, w_presc_d;
    logic [31:0] r_pcnt_q, w_pcnt_d;
    logic [3:0]  r_ctrl_q, w_ctrl_d;
    logic        r_run_q, w_run_d;
    logic        r_to_q, w_to_d;
    logic        r_reload_q, w_reload_d;

    logic w_wr_status, w_wr_ctrl, w_wr_pl, w_wr_ph, w_wr_snap, w_wr_presc;
    logic w_start, w_stop, w_tick, w_timeout;

    always_comb begin
        w_wr_status = i_wr && (i_reg == REG_STATUS);
        w_wr_ctrl   = i_wr && (i_reg == REG_CONTROL);
        w_wr_pl     = i_wr && (i_reg == REG_PERIOD_L);
        w_wr_ph     = i_wr && (i_reg == REG_PERIOD_H);
        w_wr_snap   = i_wr && ((i_reg == REG_SNAP_L) || (i_reg == REG_SNAP_H));
        w_wr_presc  = i_wr && (i_reg == REG_PRESCALE);

        w_start = w_wr_ctrl && i_wdata[c_ctrl_start_bit];
        w_stop  = w_wr_ctrl && i_wdata[c_ctrl_stop_bit];

        w_tick    = r_run_q && (r_pcnt_q == '0);
        // The forced reload owns the counter for its cycle, so no event fires then.
        w_timeout = w_tick && (r_count_q == '0) && !r_reload_q;

        w_period_d = r_period_q;
        if (w_wr_pl) begin
            w_period_d = {r_period_q[63:32], i_wdata} & c_cnt_mask;
        end else if (w_wr_ph) begin
            w_period_d = {i_wdata, r_period_q[31:0]} & c_cnt_mask;
        end
        w_reload_d = w_wr_pl || w_wr_ph;

        w_presc_d = r_presc_q;
        if (w_wr_presc) begin
            w_presc_d = i_wdata & c_presc_mask;
        end

        w_pcnt_d = r_pcnt_q;
        if (r_reload_q || w_tick) begin
            w_pcnt_d = r_presc_q;
        end else if (r_run_q) begin
            w_pcnt_d = r_pcnt_q - 32'd1;
        end

        w_count_d = r_count_q;
        if (r_reload_q) begin
            w_count_d = r_period_q;
        end else if (w_tick) begin
            w_count_d = (r_count_q == '0) ? r_period_q : (r_count_q - 64'd1);
        end

        w_run_d = r_run_q;
        if (w_timeout && !r_ctrl_q[c_ctrl_cont_bit]) begin
            w_run_d = 1'b0;
        end
        if (w_stop || r_reload_q) begin
            w_run_d = 1'b0;
        end
        if (w_start) begin
            w_run_d = 1'b1;
        end

        // A timeout in the same cycle as a STATUS write must survive.
        w_to_d = r_to_q;
        if (w_wr_status) begin
            w_to_d = 1'b0;
        end
        if (w_timeout) begin
            w_to_d = 1'b1;
        end

        w_ctrl_d = w_wr_ctrl ? i_wdata[3:0] : r_ctrl_q;
        w_snap_d = w_wr_snap ? r_count_q : r_snap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q  <= c_reset_period;
            r_period_q <= c_reset_period;
            r_snap_q   <= '0;
            r_presc_q  <= '0;
            r_pcnt_q   <= '0;
            r_ctrl_q   <= '0;
            r_run_q    <= 1'b0;
            r_to_q     <= 1'b0;
            r_reload_q <= 1'b0;
        end else begin
            r_count_q  <= w_count_d;
            r_period_q <= w_period_d;
            r_snap_q   <= w_snap_d;
            r_presc_q  <= w_presc_d;
            r_pcnt_q   <= w_pcnt_d;
            r_ctrl_q   <= w_ctrl_d;
            r_run_q    <= w_run_d;
            r_to_q     <= w_to_d;
            r_reload_q <= w_reload_d;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_reg)
            REG_STATUS:   o_rdata = {30'd0, r_run_q, r_to_q};
            REG_CONTROL:  o_rdata = {28'd0, r_ctrl_q};
            REG_PERIOD_L: o_rdata = r_period_q[31:0];
            REG_PERIOD_H: o_rdata = r_period_q[63:32];
            REG_SNAP_L:   o_rdata = r_snap_q[31:0];
            REG_SNAP_H:   o_rdata = r_snap_q[63:32];
            REG_PRESCALE: o_rdata = r_presc_q;
            default:      o_rdata = '0;
        endcase
    end

    assign o_irq = r_to_q && r_ctrl_q[c_ctrl_ito_bit];

endmodule
`default_nettype wire

// File: rtl/niosbase_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : niosbase_timer_multi
// Brief    : Multi-channel Avalon-MM interval timer with aggregated interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module niosbase_timer_multi
    import niosbase_timer_pkg::*;
#(
    parameter int          CHANNELS     = 2,
    parameter int          COUNTER_W    = 32,
    parameter int          PRESC_W      = 16,
    parameter logic [63:0] RESET_PERIOD = 64'd499999
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(CHANNELS)+2:0]  address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq,
    output logic [CHANNELS-1:0]          irq_vec
);

    localparam logic [c_chan_idx_w:0] c_nchan = (c_chan_idx_w + 1)'(CHANNELS);

    addr_split_t w_addr;
    logic        w_wr;
    logic        w_in_range;
    logic [31:0] w_chan_rdata [CHANNELS];
    logic [31:0] w_rdata_d;
    logic [31:0] r_rdata_q;

    assign w_addr     = split_addr(c_addr_max_w'(address));
    assign w_wr       = chipselect && !write_n;
    assign w_in_range = ({1'b0, w_addr.chan} < c_nchan);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic w_chan_wr;
        assign w_chan_wr = w_wr && (w_addr.chan == c_chan_idx_w'(i));

        niosbase_timer_chan #(
            .COUNTER_W    (COUNTER_W),
            .PRESC_W      (PRESC_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (w_chan_wr),
            .i_reg   (w_addr.idx),
            .i_wdata (writedata),
            .o_rdata (w_chan_rdata[i]),
            .o_irq   (irq_vec[i])
        );
    end

    always_comb begin
        w_rdata_d = '0;
        if (w_in_range) begin
            if (w_addr.idx == REG_PENDING) begin
                w_rdata_d = 32'(irq_vec);
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w_addr.chan == c_chan_idx_w'(i)) begin
                        w_rdata_d = w_chan_rdata[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata_q <= '0;
        end else begin
            r_rdata_q <= w_rdata_d;
        end
    end

    assign readdata = r_rdata_q;
    assign irq      = |irq_vec;

endmodule
`default_nettype wire

// File: tb/tb_niosbase_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_niosbase_timer_multi
// Brief    : Directed bench; a 2-channel 32-bit and a 3-channel 40-bit timer
//            share one bus (the 32-bit one sees the low four address bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_niosbase_timer_multi;
    import niosbase_timer_pkg::*;

    localparam logic [63:0] c_rst_period = 64'd499999;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write_n;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic [31:0] rdata_a, rdata_b;
    logic        irq_a, irq_b;
    logic [1:0]  irq_vec_a;
    logic [2:0]  irq_vec_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] da, db;
    int t0, t1, t2, first;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    niosbase_timer_multi #(
        .CHANNELS(2), .COUNTER_W(32), .PRESC_W(16), .RESET_PERIOD(c_rst_period)
    ) u_dut_a (
        .clk(clk), .reset(reset), .address(address[3:0]), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata_a),
        .irq(irq_a), .irq_vec(irq_vec_a)
    );

    niosbase_timer_multi #(
        .CHANNELS(3), .COUNTER_W(40), .PRESC_W(16), .RESET_PERIOD(c_rst_period)
    ) u_dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata_b),
        .irq(irq_b), .irq_vec(irq_vec_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] reg_addr(input int ch, input logic [2:0] r);
        return 5'(ch * 8) | {2'b00, r};
    endfunction

    task automatic bus_write(input int ch, input logic [2:0] r, input logic [31:0] d);
        @(negedge clk);
        address    = reg_addr(ch, r);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input int ch, input logic [2:0] r,
                            output logic [31:0] ra, output logic [31:0] rb);
        @(negedge clk);
        address    = reg_addr(ch, r);
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        ra = rdata_a;
        rb = rdata_b;
        chipselect = 1'b0;
    endtask

    // Returns the cycle at which ch1's interrupt is first seen, or -1.
    task automatic wait_irq1(input int maxc, output int at);
        at = -1;
        for (int k = 0; k < maxc && at < 0; k++) begin
            @(negedge clk);
            if (irq_vec_a[1]) at = cyc;
        end
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        check_val("rst_readdata", rdata_a, 0);
        check_val("rst_irq", irq_a, 0);
        check_val("rst_irq_vec_b", irq_vec_b, 0);
        reset = 1'b0;

        bus_read(0, REG_STATUS, da, db);   check_val("rst_status", da, 0);
        bus_read(0, REG_CONTROL, da, db);  check_val("rst_control", da, 0);
        bus_read(0, REG_PERIOD_L, da, db); check_val("rst_period_l_a", da, 32'd499999);
        check_val("rst_period_l_b", db, 32'd499999);
        bus_read(0, REG_PERIOD_H, da, db); check_val("rst_period_h", da, 0);
        bus_read(0, REG_SNAP_L, da, db);   check_val("rst_snap_l", da, 0);
        bus_read(0, REG_PRESCALE, da, db); check_val("rst_prescale", da, 0);
        bus_read(0, REG_PENDING, da, db);  check_val("rst_pending", da, 0);

        // ch1 continuous: (9+1)*(3+1) = 40 cycles per event.
        bus_write(1, REG_PERIOD_L, 32'd9);
        bus_write(1, REG_PRESCALE, 32'd3);
        bus_write(1, REG_CONTROL, 32'h7);
        wait_irq1(100, t0);
        check_val("ch1_b_irq", irq_vec_b[1], 1);
        bus_read(0, REG_PENDING, da, db);
        check_val("pending_a", da, 32'h2);
        check_val("pending_b", db, 32'h2);
        bus_write(1, REG_STATUS, 32'd0);
        check_val("ch1_irq_drop", irq_vec_a[1], 0);
        wait_irq1(100, t1);
        bus_write(1, REG_STATUS, 32'd0);
        wait_irq1(100, t2);
        bus_write(1, REG_STATUS, 32'd0);
        check_val("ch1_interval1", 64'(t1 - t0), 40);
        check_val("ch1_interval2", 64'(t2 - t1), 40);
        check_val("ch0_untouched_irq", irq_vec_a[0], 0);
        bus_read(0, REG_STATUS, da, db);   check_val("ch0_untouched_sts", da, 0);
        bus_write(1, REG_CONTROL, 32'h8);
        bus_write(1, REG_STATUS, 32'd0);

        // ch0 one-shot, period 4: event on the 5th cycle after START.
        bus_write(0, REG_PERIOD_L, 32'd4);
        bus_write(0, REG_CONTROL, 32'h5);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (irq_vec_a[0] && first == 0) first = k;
        end
        check_val("oneshot_latency", 64'(first), 5);
        bus_read(0, REG_STATUS, da, db);   check_val("oneshot_status", da, 32'h1);
        bus_write(0, REG_SNAP_L, 32'd0);
        bus_read(0, REG_SNAP_L, da, db);   check_val("oneshot_count", da, 32'd4);
        bus_write(0, REG_STATUS, 32'd0);
        repeat (20) @(negedge clk);
        check_val("oneshot_single", irq_vec_a[0], 0);

        // Period write on a running channel stops it and reloads the counter.
        bus_write(0, REG_CONTROL, 32'h6);
        bus_write(0, REG_PERIOD_L, 32'd100);
        @(negedge clk);
        bus_read(0, REG_STATUS, da, db);   check_val("reload_run", da[c_sts_run_bit], 0);
        bus_write(0, REG_SNAP_L, 32'd0);
        bus_read(0, REG_SNAP_L, da, db);   check_val("reload_count", da, 32'd100);
        bus_write(0, REG_CONTROL, 32'hC);
        bus_read(0, REG_STATUS, da, db);   check_val("start_over_stop", da[c_sts_run_bit], 1);
        bus_read(0, REG_CONTROL, da, db);  check_val("control_readback", da, 32'hC);
        bus_write(0, REG_CONTROL, 32'h8);
        bus_write(0, REG_STATUS, 32'd0);

        // Period 0 continuous: every cycle is a timeout, so STATUS write coincides.
        bus_write(0, REG_PERIOD_L, 32'd0);
        bus_write(0, REG_CONTROL, 32'h7);
        repeat (3) @(negedge clk);
        bus_write(0, REG_STATUS, 32'd0);
        check_val("to_over_clear", irq_vec_a[0], 1);

        // Wide counter on the 40-bit instance.
        bus_write(1, REG_PERIOD_H, 32'h1);
        bus_write(1, REG_PERIOD_L, 32'h0);
        bus_write(1, REG_SNAP_H, 32'd0);
        bus_read(1, REG_SNAP_H, da, db);
        check_val("snap_h_b", db, 32'h1);
        check_val("snap_h_a", da, 32'h0);
        bus_write(1, REG_PERIOD_H, 32'hFFFF_FFFF);
        bus_read(1, REG_PERIOD_H, da, db);
        check_val("period_h_trunc_b", db, 32'hFF);
        check_val("period_h_trunc_a", da, 32'h0);
        bus_read(2, REG_PERIOD_L, da, db); check_val("ch2_period_l_b", db, 32'd499999);
        bus_read(3, REG_PERIOD_L, da, db); check_val("oor_period_l_b", db, 32'd0);
        bus_read(2, REG_PENDING, da, db);  check_val("pending_ch2_win_b", db, 32'h1);
        bus_read(3, REG_PENDING, da, db);  check_val("oor_pending_b", db, 32'd0);

        // Reset while ch0 is firing.
        check_val("pre_reset_irq", irq_a, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("reset_irq_a", irq_a, 0);
        check_val("reset_irq_b", irq_b, 0);
        check_val("reset_readdata", rdata_b, 0);
        reset = 1'b0;
        bus_read(0, REG_STATUS, da, db);   check_val("post_rst_status", da, 0);
        bus_read(0, REG_PERIOD_L, da, db); check_val("post_rst_period", da, 32'd499999);
        bus_read(1, REG_PERIOD_H, da, db); check_val("post_rst_period_h_b", db, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
